// File: rtl/sssp_pkg.sv
// Shared definitions for the SSSP update path: word layout, partition
// extraction and the drain FSM encoding.
package sssp_pkg;

  localparam int unsigned UPD_W    = 64;
  localparam int unsigned VAL_MSB  = 63;
  localparam int unsigned VAL_LSB  = 32;
  localparam int unsigned DEST_MSB = 31;
  localparam int unsigned DEST_LSB = 0;
  localparam int unsigned VAL_W    = VAL_MSB - VAL_LSB + 1;
  localparam int unsigned DEST_W   = DEST_MSB - DEST_LSB + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } drain_state_e;

  // Partition index of an update: bin_w destination bits just above the
  // in-partition vertex offset.
  function automatic logic [DEST_W-1:0] bin_of(
    input logic [UPD_W-1:0] word,
    input int unsigned      par_size_w,
    input int unsigned      bin_w
  );
    logic [DEST_W-1:0] dest;
    logic [DEST_W-1:0] mask;
    dest = word[DEST_MSB:DEST_LSB];
    mask = (DEST_W'(1) << bin_w) - DEST_W'(1);
    return (dest >> par_size_w) & mask;
  endfunction

endpackage

// File: rtl/sssp_bin_fifo.sv
// Single-clock FIFO with combinational head; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sssp_bin_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             wr_en;
  logic             rd_en;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr];
  assign count = cnt;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array carries no reset; only pointers define valid contents
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sssp_update_binner.sv
// Sorts scatter updates into per-partition bins and drains bursts
// round-robin to the update-memory writer.
module sssp_update_binner
  import sssp_pkg::*;
#(
  parameter int unsigned NUM_BINS    = 4,
  parameter int unsigned BIN_DEPTH   = 16,
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned PAR_SIZE_W  = 18,
  parameter int unsigned STALL_SLACK = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [UPD_W-1:0]            in_word,
  input  logic                        in_valid,
  input  logic                        flush,
  output logic                        stall_req,
  output logic [UPD_W-1:0]            out_word,
  output logic [$clog2(NUM_BINS)-1:0] out_bin,
  output logic                        out_valid,
  output logic                        out_last,
  input  logic                        out_ready,
  output logic                        flush_done,
  output logic                        overflow,
  output logic [15:0]                 drop_cnt
);

  localparam int unsigned BIN_W    = $clog2(NUM_BINS);
  localparam int unsigned CNT_W    = $clog2(BIN_DEPTH) + 1;
  localparam int unsigned BEAT_W   = $clog2(BURST_LEN) + 1;
  localparam int unsigned STALL_TH = BIN_DEPTH - STALL_SLACK;

  logic [BIN_W-1:0]    in_bin;
  logic [NUM_BINS-1:0] push_v;
  logic [NUM_BINS-1:0] pop_v;
  logic [NUM_BINS-1:0] full_v;
  logic [NUM_BINS-1:0] empty_v;
  logic [NUM_BINS-1:0] elig_v;
  logic [UPD_W-1:0]    head [NUM_BINS];
  logic [CNT_W-1:0]    cnt  [NUM_BINS];

  drain_state_e     state;
  drain_state_e     state_d;
  logic [BIN_W-1:0] bin_q;
  logic [BIN_W-1:0] bin_d;
  logic [BIN_W-1:0] rr_q;
  logic [BIN_W-1:0] rr_d;
  logic [BEAT_W-1:0] beat_q;
  logic [BEAT_W-1:0] beat_d;
  logic             hold_q;
  logic             hold_d;

  logic             pick_valid;
  logic [BIN_W-1:0] pick_bin;
  logic             fire;
  logic             last_c;
  logic             drop;
  logic             stall_d;

  assign in_bin = BIN_W'(bin_of(in_word, PAR_SIZE_W, BIN_W));

  // One FIFO per destination partition
  for (genvar b = 0; b < NUM_BINS; b++) begin : g_bin
    assign push_v[b] = in_valid && (in_bin == BIN_W'(b));
    assign pop_v[b]  = fire && (bin_q == BIN_W'(b));
    assign elig_v[b] = (cnt[b] >= CNT_W'(BURST_LEN)) || (flush && !empty_v[b]);

    sssp_bin_fifo #(
      .WIDTH (UPD_W),
      .DEPTH (BIN_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_v[b]),
      .pop   (pop_v[b]),
      .din   (in_word),
      .dout  (head[b]),
      .count (cnt[b]),
      .full  (full_v[b]),
      .empty (empty_v[b])
    );
  end

  // Beat presentation straight from the active bin's head
  assign out_valid  = (state == BURST) && !empty_v[bin_q];
  assign out_word   = out_valid ? head[bin_q] : '0;
  assign last_c     = (beat_q == BEAT_W'(BURST_LEN - 1)) || (cnt[bin_q] == CNT_W'(1)) || hold_q;
  assign out_last   = out_valid && last_c;
  assign out_bin    = bin_q;
  assign fire       = out_valid && out_ready;
  assign flush_done = flush && (&empty_v) && (state == IDLE);

  // First eligible bin at or after the round-robin pointer
  always_comb begin
    logic [BIN_W-1:0] idx;
    pick_valid = 1'b0;
    pick_bin   = rr_q;
    idx        = '0;
    for (int unsigned i = 0; i < NUM_BINS; i++) begin
      idx = rr_q + BIN_W'(i);
      if (!pick_valid && elig_v[idx]) begin
        pick_valid = 1'b1;
        pick_bin   = idx;
      end
    end
  end

  // Drain FSM next-state; hold_d pins out_last once shown on a stalled beat
  // so a concurrent push into the active bin cannot retract it.
  always_comb begin
    state_d = state;
    bin_d   = bin_q;
    beat_d  = beat_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_d = BURST;
          bin_d   = pick_bin;
          beat_d  = '0;
          hold_d  = 1'b0;
        end
      end
      BURST: begin
        if (fire) begin
          beat_d = beat_q + BEAT_W'(1);
          hold_d = 1'b0;
          if (last_c) begin
            state_d = IDLE;
            rr_d    = bin_q + BIN_W'(1);
          end
        end else if (out_valid) begin
          hold_d = last_c;
        end else begin
          state_d = IDLE;
          rr_d    = bin_q + BIN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      bin_q  <= '0;
      rr_q   <= '0;
      beat_q <= '0;
      hold_q <= 1'b0;
    end else begin
      state  <= state_d;
      bin_q  <= bin_d;
      rr_q   <= rr_d;
      beat_q <= beat_d;
      hold_q <= hold_d;
    end
  end

  // Drop accounting and early stall toward the edge feeder
  assign drop = in_valid && full_v[in_bin] && !pop_v[in_bin];

  always_comb begin
    stall_d = 1'b0;
    for (int unsigned i = 0; i < NUM_BINS; i++) begin
      if (cnt[i] >= CNT_W'(STALL_TH)) stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_req <= 1'b0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      stall_req <= stall_d;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'(1);
      end
    end
  end

endmodule

// File: tb/tb_sssp_update_binner.sv
// Scoreboard bench for sssp_update_binner: directed update streams with
// expected beats queued at issue time and checked by a separate monitor.
module tb_sssp_update_binner;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_word;
  logic        in_valid;
  logic        flush;
  logic        stall_req;
  logic [63:0] out_word;
  logic [1:0]  out_bin;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        flush_done;
  logic        overflow;
  logic [15:0] drop_cnt;

  sssp_update_binner #(
    .NUM_BINS(4), .BIN_DEPTH(16), .BURST_LEN(8), .PAR_SIZE_W(18), .STALL_SLACK(4)
  ) dut (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .flush(flush),
    .stall_req(stall_req), .out_word(out_word), .out_bin(out_bin),
    .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .flush_done(flush_done), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  bin;
    logic [63:0] word;
    logic        last;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   prev_cyc = 0;
  logic prev_last = 1'b0;
  logic chk_gap = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [31:0] val, input logic [31:0] dest);
    return {val, dest};
  endfunction

  task automatic expect_beat(input logic [1:0] b, input logic [63:0] w, input logic l);
    exp_t e;
    e.bin = b; e.word = w; e.last = l;
    q.push_back(e);
  endtask

  task automatic drive(input logic [63:0] w);
    in_word  = w;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_bin"}, out_bin, 0);
    chk({tag, "_stall_req"}, stall_req, 0);
    chk({tag, "_flush_done"}, flush_done, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
    chk({tag, "_out_word"}, out_word, 0);
  endtask

  // Monitor: compare each accepted beat with the scoreboard head
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_beat: got word %0h, required no beat", out_word);
      end else if (out_ready) begin
        e_mon = q.pop_front();
        chk("beat_word", out_word, e_mon.word);
        chk("beat_bin", out_bin, e_mon.bin);
        chk("beat_last", out_last, e_mon.last);
        if (chk_gap && prev_last) chk("burst_gap", 64'(cyc - prev_cyc), 2);
        prev_last = out_last;
        prev_cyc  = cyc;
      end else begin
        chk("hold_word", out_word, q[0].word);
        chk("hold_last", out_last, q[0].last);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;
    rst = 1'b0; in_word = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst0");
    rst = 1'b1;
    @(posedge clk); #1;

    // Full burst on bin 1, two-cycle latency from last push
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w = mk(32'h100 + 32'(i), 32'h40000 + 32'(i));
      expect_beat(2'd1, w, i == 7);
      drive(w);
    end
    chk("t1_lat_idle", out_valid, 0);
    @(posedge clk); #1;
    chk("t1_lat_first", out_valid, 1);
    chk("t1_bin", out_bin, 1);
    wait_drain("t1");

    // Reset pulse returns rr_ptr to 0
    rst = 1'b0; #1;
    check_reset_vals("rst1");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Bins 0 and 3 full, bin 0 first, one idle cycle, then bin 3
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w = mk(32'h300 + 32'(i), 32'h00000 + 32'(i));
      expect_beat(2'd0, w, i == 7);
      drive(w);
    end
    for (int i = 0; i < 8; i++) begin
      w = mk(32'h330 + 32'(i), 32'hC0000 + 32'(i));
      expect_beat(2'd3, w, i == 7);
      drive(w);
    end
    chk("t3_pending_valid", out_valid, 1);
    chk("t3_pending_bin", out_bin, 0);
    prev_last = 1'b0;
    chk_gap   = 1'b1;
    out_ready = 1'b1;
    wait_drain("t3");
    chk_gap = 1'b0;

    // Partial bins drained by flush; rr_ptr=0 puts bin 0 ahead of bin 2
    for (int i = 0; i < 2; i++) expect_beat(2'd0, mk(32'h210 + 32'(i), 32'h10 + 32'(i)), i == 1);
    for (int i = 0; i < 3; i++) expect_beat(2'd2, mk(32'h200 + 32'(i), 32'h80000 + 32'(i)), i == 2);
    for (int i = 0; i < 3; i++) drive(mk(32'h200 + 32'(i), 32'h80000 + 32'(i)));
    for (int i = 0; i < 2; i++) drive(mk(32'h210 + 32'(i), 32'h10 + 32'(i)));
    chk("t2_no_burst", out_valid, 0);
    chk("t2_flush_done_pre", flush_done, 0);
    flush = 1'b1;
    wait_drain("t2");
    chk("t2_flush_done", flush_done, 1);
    flush = 1'b0; #1;
    chk("t2_flush_done_low", flush_done, 0);

    // out_ready toggling during a burst
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w = mk(32'h400 + 32'(i), 32'h40020 + 32'(i));
      expect_beat(2'd1, w, i == 7);
      drive(w);
    end
    for (int k = 0; k < 20; k++) begin
      out_ready = (k % 2 == 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_drain("t4");

    // Bin 0 overfill with writer stalled: stall_req, drop on 17th
    out_ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      w = mk(32'h500 + 32'(i), 32'h00040 + 32'(i));
      if (i <= 16) expect_beat(2'd0, w, (i == 8) || (i == 16));
      drive(w);
      chk($sformatf("t5_stall_%0d", i), stall_req, i >= 13);
      chk($sformatf("t5_drop_%0d", i), drop_cnt, (i >= 17) ? 1 : 0);
      chk($sformatf("t5_ovf_%0d", i), overflow, i >= 17);
    end

    // Push into full bin 0 while it is popped: accepted, no new drop
    w = mk(32'h5FF, 32'h00077);
    expect_beat(2'd0, w, 1'b0);
    in_word = w; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t6_drop", drop_cnt, 1);
    chk("t6_ovf", overflow, 1);
    chk("t6_stall", stall_req, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_mid_burst", out_valid, 1);

    // Asynchronous reset mid-burst
    rst = 1'b0; #1;
    check_reset_vals("rst2");
    q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_idle", out_valid, 0);
    chk("post_rst_drop", drop_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
